error_power_monitor: RTL and testbench

- Sits directly downstream of the adaptive filter and consumes its signed error sample stream and overflow flag.
- Computes the mean-square error (MSE) over fixed windows of 2^LOG2_WIN accepted samples.
- Runs a convergence state machine with hold-off qualification and reports MSE, lock status and overflow-tainted windows to control logic.
- Step-size scheduling and weight freezing are driven from this block's outputs.

---
 rtl/error_power_monitor.sv | 137 +++++++++++++
 tb/tb_error_power_monitor.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/error_power_monitor.sv
// Windowed mean-square-error monitor for the adaptive filter error stream,
// with a SEARCH/QUALIFY/LOCKED convergence tracker.
module error_power_monitor #(
    parameter int WIDTH    = 16,
    parameter int FRAC     = 12,
    parameter int LOG2_WIN = 6,
    parameter int HOLD     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_valid,
    input  logic signed [WIDTH-1:0] i_error,
    input  logic                    i_ovr,
    input  logic                    i_clear,
    input  logic        [WIDTH-1:0] i_threshold,
    output logic        [WIDTH-1:0] o_mse,
    output logic                    o_mse_valid,
    output logic                    o_ovr_window,
    output logic                    o_converged,
    output logic        [1:0]       o_state
);

    localparam int SQ_W  = 2*WIDTH - FRAC;
    localparam int ACC_W = SQ_W + LOG2_WIN;
    localparam int QW    = $clog2(HOLD + 1);
    localparam logic [QW-1:0]       HOLD_Q = QW'(HOLD);
    localparam logic [LOG2_WIN-1:0] LAST   = '1;
    localparam logic [SQ_W-1:0]     MAX_MSE = SQ_W'({WIDTH{1'b1}});

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        QUALIFY = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    logic signed [2*WIDTH-1:0] prod;
    logic [SQ_W-1:0]           sq;
    logic [ACC_W-1:0]          acc;
    logic [ACC_W-1:0]          sum;
    logic [SQ_W-1:0]           mean;
    logic [WIDTH-1:0]          mean_sat;
    logic [LOG2_WIN-1:0]       count;
    logic                      taint;
    logic                      taint_now;
    logic                      accept;
    logic                      window_end;
    logic                      good;
    state_t                    state;
    state_t                    state_next;
    logic [QW-1:0]             qual;
    logic [QW-1:0]             qual_next;
    logic [QW-1:0]             qual_inc;

    // The square of the most negative input is 2^(2*WIDTH-2), which still fits the signed product.
    assign prod       = (2*WIDTH)'(i_error) * (2*WIDTH)'(i_error);
    assign sq         = SQ_W'(prod >> FRAC);
    assign sum        = acc + ACC_W'(sq);
    assign mean       = SQ_W'(sum >> LOG2_WIN);
    assign mean_sat   = (mean > MAX_MSE) ? '1 : mean[WIDTH-1:0];
    assign taint_now  = taint | i_ovr;
    assign accept     = i_valid && !i_clear;
    assign window_end = accept && (count == LAST);
    assign good       = !taint_now && (mean_sat < i_threshold);
    assign qual_inc   = qual + QW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc          <= '0;
            count        <= '0;
            taint        <= 1'b0;
            o_mse        <= '0;
            o_mse_valid  <= 1'b0;
            o_ovr_window <= 1'b0;
        end else if (i_clear) begin
            acc         <= '0;
            count       <= '0;
            taint       <= 1'b0;
            o_mse_valid <= 1'b0;
        end else begin
            o_mse_valid <= 1'b0;
            if (window_end) begin
                o_mse        <= mean_sat;
                o_mse_valid  <= 1'b1;
                o_ovr_window <= taint_now;
                acc          <= '0;
                count        <= '0;
                taint        <= 1'b0;
            end else if (accept) begin
                acc   <= sum;
                count <= count + LOG2_WIN'(1);
                taint <= taint_now;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            state <= SEARCH;
            qual  <= '0;
        end else begin
            state <= state_next;
            qual  <= qual_next;
        end
    end

    // Transitions happen only on a window-ending accept; a bad window always falls back to SEARCH.
    always_comb begin
        state_next = state;
        qual_next  = qual;
        if (window_end) begin
            if (!good) begin
                state_next = SEARCH;
                qual_next  = '0;
            end else begin
                case (state)
                    SEARCH: begin
                        qual_next  = QW'(1);
                        state_next = (HOLD_Q == QW'(1)) ? LOCKED : QUALIFY;
                    end
                    QUALIFY: begin
                        qual_next  = qual_inc;
                        state_next = (qual_inc >= HOLD_Q) ? LOCKED : QUALIFY;
                    end
                    LOCKED:  state_next = LOCKED;
                    default: begin
                        state_next = SEARCH;
                        qual_next  = '0;
                    end
                endcase
            end
        end
    end

    assign o_state     = state;
    assign o_converged = (state == LOCKED);

endmodule

// File: tb/tb_error_power_monitor.sv
// Scoreboard bench for error_power_monitor: a window-level reference model
// predicts each MSE report; a negedge monitor pops and compares every pulse.
module tb_error_power_monitor;

    localparam int WIDTH    = 16;
    localparam int FRAC     = 12;
    localparam int LOG2_WIN = 2;
    localparam int HOLD     = 2;
    localparam int WIN      = 1 << LOG2_WIN;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    i_valid = 1'b0;
    logic signed [WIDTH-1:0] i_error = '0;
    logic                    i_ovr = 1'b0;
    logic                    i_clear = 1'b0;
    logic        [WIDTH-1:0] i_threshold = '0;
    logic        [WIDTH-1:0] o_mse;
    logic                    o_mse_valid;
    logic                    o_ovr_window;
    logic                    o_converged;
    logic        [1:0]       o_state;

    int errors = 0;
    int checks = 0;

    typedef struct {
        longint mse;
        bit     ovr;
        int     state;
        bit     conv;
    } exp_t;

    exp_t   exp_q[$];
    longint win_sq[$];
    bit     m_taint = 0;
    int     m_state = 0;
    int     m_qual  = 0;

    error_power_monitor #(
        .WIDTH(WIDTH), .FRAC(FRAC), .LOG2_WIN(LOG2_WIN), .HOLD(HOLD)
    ) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_error(i_error), .i_ovr(i_ovr),
        .i_clear(i_clear), .i_threshold(i_threshold), .o_mse(o_mse),
        .o_mse_valid(o_mse_valid), .o_ovr_window(o_ovr_window),
        .o_converged(o_converged), .o_state(o_state)
    );

    always #5 clk = ~clk;

    function automatic void checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endfunction

    // Reference model: gather squares of a window, then apply the mean and lock rules.
    function automatic void modelStep(input bit v, input int e, input bit ovr, input bit clr, input int thr);
        logic signed [WIDTH-1:0] es;
        longint ee, total, mean;
        bit     good, tainted;
        exp_t   x;
        if (clr) begin
            win_sq.delete();
            m_taint = 0;
            m_state = 0;
            m_qual  = 0;
            return;
        end
        if (!v) return;
        es = WIDTH'(e);
        ee = es;
        win_sq.push_back((ee * ee) >> FRAC);
        m_taint = m_taint | ovr;
        if (win_sq.size() == WIN) begin
            total = 0;
            foreach (win_sq[k]) total += win_sq[k];
            mean = total / WIN;
            if (mean > 65535) mean = 65535;
            tainted = m_taint;
            good = !tainted && (mean < thr);
            if (!good) begin
                m_state = 0;
                m_qual  = 0;
            end else if (m_state == 0) begin
                m_qual  = 1;
                m_state = (HOLD == 1) ? 2 : 1;
            end else if (m_state == 1) begin
                m_qual++;
                if (m_qual >= HOLD) m_state = 2;
            end
            x.mse = mean; x.ovr = tainted; x.state = m_state; x.conv = (m_state == 2);
            exp_q.push_back(x);
            win_sq.delete();
            m_taint = 0;
        end
    endfunction

    task automatic applyStimulus(input bit v, input int e, input bit ovr, input bit clr, input int thr);
        i_valid     = v;
        i_error     = WIDTH'(e);
        i_ovr       = ovr;
        i_clear     = clr;
        i_threshold = WIDTH'(thr);
        @(posedge clk);
        modelStep(v, e, ovr, clr, thr);
        #1;
    endtask

    task automatic runWindow(input int e, input bit ovr3, input int thr);
        for (int i = 0; i < WIN; i++) applyStimulus(1, e, ovr3 && (i == 2), 0, thr);
    endtask

    // Monitor: every reported window must match the oldest prediction.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (!rst && o_mse_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_pulse", 1, 0);
                end else begin
                    x = exp_q.pop_front();
                    checkOutput("o_mse", o_mse, x.mse);
                    checkOutput("o_ovr_window", o_ovr_window, x.ovr);
                    checkOutput("o_state", o_state, x.state);
                    checkOutput("o_converged", o_converged, x.conv);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int e, thr;
        bit v, ovr, clr;

        i_valid = 1'b1;
        i_error = 16'sh7FFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_mse", o_mse, 0);
        checkOutput("reset_valid", o_mse_valid, 0);
        checkOutput("reset_ovr", o_ovr_window, 0);
        checkOutput("reset_conv", o_converged, 0);
        checkOutput("reset_state", o_state, 0);
        rst = 1'b0;

        runWindow(2048, 0, 1024);
        applyStimulus(0, 0, 0, 0, 1024);
        checkOutput("basic_state", o_state, 0);

        repeat (3) runWindow(-1024, 0, 512);
        runWindow(-1024, 1, 512);
        runWindow(-1024, 0, 512);

        for (int i = 0; i < WIN; i++) begin
            applyStimulus(1, -32768, 0, 0, 512);
            applyStimulus(0, 0, 0, 0, 512);
        end

        applyStimulus(1, 4000, 0, 0, 1024);
        applyStimulus(1, 4000, 0, 0, 1024);
        applyStimulus(0, 0, 0, 1, 1024);
        runWindow(2048, 0, 1024);

        repeat (2) runWindow(-1024, 0, 512);
        for (int i = 0; i < WIN - 1; i++) applyStimulus(1, 2048, 0, 0, 512);
        applyStimulus(1, 2048, 0, 1, 512);
        @(negedge clk);
        checkOutput("clear_state", o_state, 0);
        checkOutput("clear_conv", o_converged, 0);
        checkOutput("clear_no_pulse", o_mse_valid, 0);

        for (int n = 0; n < 400; n++) begin
            v   = ($urandom_range(0, 3) != 0);
            ovr = ($urandom_range(0, 31) == 0);
            clr = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 9) == 0) e = int'($urandom_range(0, 65535)) - 32768;
            else e = int'($urandom_range(0, 2048)) - 1024;
            thr = int'($urandom_range(0, 400));
            applyStimulus(v, e, ovr, clr, thr);
        end

        applyStimulus(0, 0, 0, 0, 0);
        repeat (4) @(negedge clk);
        checkOutput("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
